// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot controller: sequencer
// states, default geometry and the NOP returned for unserved fetches.
package imem_pkg;

  localparam int          DEF_DEPTH_WORDS = 256;
  localparam int          DEF_ADDR_W      = 8;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RUN    = 2'd2
  } boot_state_e;

  // A fetch is served only for a word-aligned PC that falls inside the array.
  function automatic logic fetch_servable(input logic [31:0] addr,
                                          input logic [31:0] depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_boot_controller.sv
// Boot sequencer and port arbiter for the word-addressed instruction memory:
// streams an image in over valid/ready, then hands the array to fetch.
module imem_boot_controller #(
  parameter int          DEPTH_WORDS = imem_pkg::DEF_DEPTH_WORDS,
  parameter int          ADDR_W      = imem_pkg::DEF_ADDR_W,
  parameter logic [31:0] NOP_INSTR   = imem_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic              reload_req,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              core_rst,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              boot_done,
  output logic [ADDR_W:0]   load_count,
  output logic              err_overflow,
  output logic              err_misalign
);

  import imem_pkg::*;

  localparam int                CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH_WORDS);
  localparam logic [31:0]       DEPTH_U32  = 32'(DEPTH_WORDS);

  boot_state_e       r_state;
  boot_state_e       w_state_next;
  logic [ADDR_W-1:0] r_wptr;
  logic [CNT_W-1:0]  r_load_count;
  logic              r_err_overflow;
  logic              r_err_misalign;

  logic w_run;
  logic w_full;
  logic w_xfer;
  logic w_write;
  logic w_misalign;

  assign w_run      = (r_state == ST_RUN);
  assign w_full     = (r_load_count == FULL_COUNT);
  assign w_xfer     = load_valid && load_ready;
  // A restart request discards the word offered in the same cycle.
  assign w_write    = w_xfer && !w_full && !reload_req && !rst;
  assign w_misalign = w_run && (fetch_addr[1:0] != 2'b00);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal written here receives a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (reload_req) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:   if (w_xfer && load_last) w_state_next = ST_COMMIT;
        ST_COMMIT: w_state_next = ST_RUN;
        ST_RUN:    w_state_next = ST_RUN;
        default:   w_state_next = ST_LOAD;
      endcase
    end
  end

  // Write pointer and count advance together; the count stops at the depth
  // while the pointer wraps, and no write happens once the count is full.
  always_ff @(posedge clk) begin
    if (rst || reload_req) begin
      r_wptr       <= '0;
      r_load_count <= '0;
    end else if (w_write) begin
      r_wptr       <= r_wptr + 1'b1;
      r_load_count <= r_load_count + 1'b1;
    end
  end

  // Error flags survive reloads; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_overflow <= 1'b0;
      r_err_misalign <= 1'b0;
    end else begin
      if (w_xfer && w_full && !reload_req) r_err_overflow <= 1'b1;
      if (w_misalign)                      r_err_misalign <= 1'b1;
    end
  end

  always_comb begin
    load_ready  = (r_state == ST_LOAD);
    core_rst    = !w_run;
    boot_done   = w_run;
    mem_we      = w_write;
    mem_waddr   = r_wptr;
    mem_wdata   = load_data;
    mem_raddr   = '0;
    fetch_instr = NOP_INSTR;
    if (w_run) begin
      mem_raddr = fetch_addr[ADDR_W+1:2];
      if (fetch_servable(fetch_addr, DEPTH_U32)) fetch_instr = mem_rdata;
    end
  end

  assign load_count   = r_load_count;
  assign err_overflow = r_err_overflow;
  assign err_misalign = r_err_misalign;

endmodule
